instr_register_ctrl: RTL and testbench
======================================

Name: instr_register_ctrl

Overview:
- Controller and arbiter in front of the instruction register.
- Shares the register's single write port between two requesters using round-robin arbitration.
- Owns write_pointer/read_pointer as a circular queue and tracks occupancy so unread entries are never overwritten.
- Runs the register's reset sequence and serves in-order reads to one consumer with a valid handshake.

Parameters:
OP_W, 32, operand width (operand_t)
OPC_W, 4, opcode width (opcode_t)
ADDR_W, 5, pointer width (address_t)
DEPTH, 32, register entries; must equal 2**ADDR_W
INIT_CYCLES, 2, cycles ir_reset_n is held low after reset release

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
wr0_valid  in  1  requester 0 write request
wr0_ready  out  1  requester 0 write accepted this cycle
wr0_opa  in  OP_W  requester 0 operand_a
wr0_opb  in  OP_W  requester 0 operand_b
wr0_opc  in  OPC_W  requester 0 opcode
wr1_valid/wr1_ready/wr1_opa/wr1_opb/wr1_opc  same as requester 0, for requester 1
rd_req  in  1  consumer read request
rd_valid  out  1  rd_instr valid, one-cycle pulse per read
rd_instr  out  2*OP_W+OPC_W  instruction word read out
ir_load_en  out  1  to register load_en
ir_reset_n  out  1  to register reset_n
ir_operand_a  out  OP_W  to register operand_a
ir_operand_b  out  OP_W  to register operand_b
ir_opcode  out  OPC_W  to register opcode
ir_write_pointer  out  ADDR_W  to register write_pointer
ir_read_pointer  out  ADDR_W  to register read_pointer
ir_instruction_word  in  2*OP_W+OPC_W  from register instruction_word (combinational on read_pointer)
count  out  ADDR_W+1  occupied entries, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=INIT; wr_ptr=rd_ptr=0; count=0; last_grant=1.
  - rd_valid=0; rd_instr=0; ir_reset_n=0; init counter=0.
  - Combinational outputs: ready/load_en=0, empty=1, full=0.
- State INIT:
  - ir_reset_n=0; no grants; rd_req ignored.
  - After INIT_CYCLES rising edges with reset low -> RUN.
- State RUN:
  - ir_reset_n=1; stays in RUN until reset.
- Arbitration (combinational, RUN and !full only):
  - Only one valid -> that requester granted.
  - Both valid -> grant the requester not in last_grant.
  - last_grant updates on every grant.
  - First contested grant after reset goes to requester 0.
- Write path:
  - wrN_ready = grant[N]; ir_load_en = |grant.
  - ir_operand_a/b/opcode muxed from the granted requester; zero when no grant.
  - ir_write_pointer = wr_ptr (combinational).
  - On grant edge: wr_ptr += 1, wrapping DEPTH-1 -> 0.
  - Requesters hold valid and data stable until ready; the controller does not buffer requests.
- Read path:
  - ir_read_pointer = rd_ptr (combinational).
  - Read accepted when rd_req && !empty && RUN.
  - On accepted edge: rd_instr <= ir_instruction_word; rd_valid <= 1; rd_ptr += 1 with wrap.
  - rd_valid=1 the cycle after acceptance, otherwise 0; rd_instr holds its last value.
  - rd_req while empty: ignored, no rd_valid.
- Occupancy:
  - Write only: count+1. Read only: count-1. Simultaneous write and read: count unchanged, both pointers advance.
  - Full: both readies 0, including while a read occurs that cycle (write allowed the following cycle).
  - Empty with simultaneous write: read not accepted; the entry becomes readable next cycle.
- Latency: write accept to readable = 1 cycle; read accept to rd_valid = 1 cycle.

Optional Feature:
INSTR_CTRL_FIXED_PRIO_EN:
- Defined: fixed priority; requester 0 always wins a contested cycle; last_grant unused.
- Undefined: round-robin as above.

Test Plan:
- Reset held 3 cycles, then released, INIT_CYCLES=2 -> ir_reset_n=0 for 2 edges after release, then 1; no ready asserted during INIT even with wr0_valid=1.
- Both valid continuously for 4 cycles in RUN -> grants 0,1,0,1; write_pointer 0,1,2,3; count=4 (fixed-prio build: 0,0,0,0).
- Write opa=5, opb=3, opc=3 (ADD), then rd_req next cycle -> rd_valid one cycle later with rd_instr = that entry; count returns to 0; empty=1.
- Fill 32 entries -> full=1, wr0_ready=0 with wr0_valid=1; one read -> write accepted the next cycle at write_pointer=0 (wrap).
- count=3, write and read in the same cycle -> count stays 3; both pointers +1; rd_valid next cycle.
- Assert reset mid-stream with count=7 and rd_req=1 -> immediately count=0, rd_valid=0, pointers 0, ir_load_en=0; re-enters INIT.

Source files
------------

// File: rtl/instr_register_ctrl.sv
// Write arbiter, circular-queue pointer owner and reset/read sequencer for the instruction register.
// Build option: define INSTR_CTRL_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module instr_register_ctrl #(
  parameter int OP_W        = 32,
  parameter int OPC_W       = 4,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int INIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_valid,
  output logic                     wr0_ready,
  input  logic [OP_W-1:0]          wr0_opa,
  input  logic [OP_W-1:0]          wr0_opb,
  input  logic [OPC_W-1:0]         wr0_opc,
  input  logic                     wr1_valid,
  output logic                     wr1_ready,
  input  logic [OP_W-1:0]          wr1_opa,
  input  logic [OP_W-1:0]          wr1_opb,
  input  logic [OPC_W-1:0]         wr1_opc,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [2*OP_W+OPC_W-1:0]  rd_instr,
  output logic                     ir_load_en,
  output logic                     ir_reset_n,
  output logic [OP_W-1:0]          ir_operand_a,
  output logic [OP_W-1:0]          ir_operand_b,
  output logic [OPC_W-1:0]         ir_opcode,
  output logic [ADDR_W-1:0]        ir_write_pointer,
  output logic [ADDR_W-1:0]        ir_read_pointer,
  input  logic [2*OP_W+OPC_W-1:0]  ir_instruction_word,
  output logic [ADDR_W:0]          count,
  output logic                     full,
  output logic                     empty
);

  localparam int IW     = 2*OP_W + OPC_W;
  localparam int NREQ   = 2;
  localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [OPC_W-1:0]  opcode_t;
  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [ADDR_W:0]   count_t;
  typedef enum logic {INIT, RUN} state_t;

  localparam address_t LAST_ADDR  = address_t'(DEPTH - 1);
  localparam address_t ADDR_ONE   = address_t'(1);
  localparam count_t   COUNT_ONE  = count_t'(1);
  localparam count_t   FULL_COUNT = count_t'(DEPTH);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);

  state_t            state_reg;
  logic [INIT_W-1:0] init_cnt_reg;
  logic              ir_reset_n_reg;
  address_t          wr_ptr_reg;
  address_t          rd_ptr_reg;
  count_t            count_reg;
  count_t            count_next;
  logic              last_grant_reg;
  logic              rd_valid_reg;
  logic [IW-1:0]     rd_instr_reg;

  logic              run;
  logic              can_write;
  logic              wr_fire;
  logic              rd_fire;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   grant;

  operand_t req_opa [NREQ];
  operand_t req_opb [NREQ];
  opcode_t  req_opc [NREQ];
  operand_t opa_masked [NREQ];
  operand_t opb_masked [NREQ];
  opcode_t  opc_masked [NREQ];

  assign run       = (state_reg == RUN);
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign can_write = run && !full;
  assign rd_fire   = run && rd_req && !empty;
  assign wr_fire   = |grant;

  assign req_valid  = {wr1_valid, wr0_valid};
  assign req_opa[0] = wr0_opa;
  assign req_opb[0] = wr0_opb;
  assign req_opc[0] = wr0_opc;
  assign req_opa[1] = wr1_opa;
  assign req_opb[1] = wr1_opb;
  assign req_opc[1] = wr1_opc;

  // Grant is one-hot or zero; a full queue blocks writes even when a read frees a slot this cycle.
  always_comb begin
    grant = '0;
    if (can_write) begin
`ifdef INSTR_CTRL_FIXED_PRIO_EN
      if (wr0_valid)
        grant = 2'b01;
      else if (wr1_valid)
        grant = 2'b10;
`else
      if (wr0_valid && wr1_valid)
        grant = last_grant_reg ? 2'b01 : 2'b10;
      else
        grant = req_valid;
`endif
    end
  end

  // Data from the non-granted requester is masked so idle cycles drive zeros to the register.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign opa_masked[gi] = grant[gi] ? req_opa[gi] : '0;
      assign opb_masked[gi] = grant[gi] ? req_opb[gi] : '0;
      assign opc_masked[gi] = grant[gi] ? req_opc[gi] : '0;
    end
  endgenerate

  assign ir_operand_a     = opa_masked[0] | opa_masked[1];
  assign ir_operand_b     = opb_masked[0] | opb_masked[1];
  assign ir_opcode        = opc_masked[0] | opc_masked[1];
  assign wr0_ready        = grant[0];
  assign wr1_ready        = grant[1];
  assign ir_load_en       = wr_fire;
  assign ir_write_pointer = wr_ptr_reg;
  assign ir_read_pointer  = rd_ptr_reg;
  assign ir_reset_n       = ir_reset_n_reg;
  assign rd_valid         = rd_valid_reg;
  assign rd_instr         = rd_instr_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Holds the register in reset for INIT_CYCLES edges, then stays in RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= INIT;
      init_cnt_reg   <= '0;
      ir_reset_n_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (init_cnt_reg == INIT_LAST) begin
            state_reg      <= RUN;
            ir_reset_n_reg <= 1'b1;
          end else begin
            init_cnt_reg <= init_cnt_reg + INIT_ONE;
          end
        end
        RUN:     ir_reset_n_reg <= 1'b1;
        default: state_reg <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= 1'b1;
      rd_valid_reg   <= 1'b0;
      rd_instr_reg   <= '0;
    end else begin
      count_reg    <= count_next;
      rd_valid_reg <= rd_fire;
      if (wr_fire) begin
        wr_ptr_reg     <= (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + ADDR_ONE;
        last_grant_reg <= grant[1];
      end
      if (rd_fire) begin
        rd_ptr_reg   <= (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + ADDR_ONE;
        rd_instr_reg <= ir_instruction_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl with a behavioural instruction register and a read scoreboard.
module tb_instr_register_ctrl;
  localparam int OP_W   = 32;
  localparam int OPC_W  = 4;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int IW     = 2*OP_W + OPC_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr0_valid = 1'b0, wr1_valid = 1'b0, rd_req = 1'b0;
  logic wr0_ready, wr1_ready, rd_valid, ir_load_en, ir_reset_n, full, empty;
  logic [OP_W-1:0]   wr0_opa = '0, wr0_opb = '0, wr1_opa = '0, wr1_opb = '0;
  logic [OPC_W-1:0]  wr0_opc = '0, wr1_opc = '0;
  logic [OP_W-1:0]   ir_operand_a, ir_operand_b;
  logic [OPC_W-1:0]  ir_opcode;
  logic [ADDR_W-1:0] ir_write_pointer, ir_read_pointer;
  logic [IW-1:0]     rd_instr, ir_instruction_word;
  logic [ADDR_W:0]   count;

  instr_register_ctrl dut (
    .clk(clk), .reset(reset),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_opa(wr0_opa), .wr0_opb(wr0_opb), .wr0_opc(wr0_opc),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_opa(wr1_opa), .wr1_opb(wr1_opb), .wr1_opc(wr1_opc),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_instr(rd_instr),
    .ir_load_en(ir_load_en), .ir_reset_n(ir_reset_n),
    .ir_operand_a(ir_operand_a), .ir_operand_b(ir_operand_b), .ir_opcode(ir_opcode),
    .ir_write_pointer(ir_write_pointer), .ir_read_pointer(ir_read_pointer),
    .ir_instruction_word(ir_instruction_word),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural instruction register: synchronous write, combinational read.
  logic [IW-1:0] reg_mem [DEPTH];
  always @(posedge clk) if (ir_load_en) reg_mem[ir_write_pointer] <= {ir_operand_a, ir_operand_b, ir_opcode};
  assign ir_instruction_word = reg_mem[ir_read_pointer];

  int tests_run = 0;
  int tests_failed = 0;
  logic [IW-1:0]     sb_q [$];
  logic [IW-1:0]     last_rd = '0;
  logic [ADDR_W-1:0] exp_wp = '0, exp_rp = '0;
  logic [ADDR_W:0]   exp_count = '0;
  logic              wr_exp = 1'b0, rd_exp = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the write side of the current cycle; g is the expected granted requester, -1 for none.
  task automatic expect_grant(input int g, input string tag);
    logic [IW-1:0] w;
    #1;
    if (g == 0)      w = {wr0_opa, wr0_opb, wr0_opc};
    else if (g == 1) w = {wr1_opa, wr1_opb, wr1_opc};
    else             w = '0;
    check({tag, ".wr0_ready"}, wr0_ready, g == 0);
    check({tag, ".wr1_ready"}, wr1_ready, g == 1);
    check({tag, ".ir_load_en"}, ir_load_en, g >= 0);
    check({tag, ".ir_write_pointer"}, ir_write_pointer, exp_wp);
    check({tag, ".ir_data"}, {ir_operand_a, ir_operand_b, ir_opcode}, w);
    $display("[TB] %s: grant=%0d wp=%0d", tag, g, exp_wp);
    if (g >= 0) begin
      sb_q.push_back(w);
      wr_exp = 1'b1;
    end
  endtask

  // Advances one clock and checks read output, occupancy and read pointer against the model.
  task automatic tick(input string tag);
    logic [IW-1:0] e;
    @(posedge clk); #1;
    if (wr_exp) exp_wp = exp_wp + ADDR_W'(1);
    if (rd_exp) exp_rp = exp_rp + ADDR_W'(1);
    if (wr_exp && !rd_exp) exp_count = exp_count + (ADDR_W+1)'(1);
    if (rd_exp && !wr_exp) exp_count = exp_count - (ADDR_W+1)'(1);
    check({tag, ".rd_valid"}, rd_valid, rd_exp);
    if (rd_exp) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
        e = sb_q.pop_front();
        last_rd = e;
      end
    end
    check({tag, ".rd_instr"}, rd_instr, last_rd);
    check({tag, ".count"}, count, exp_count);
    check({tag, ".full"}, full, exp_count == (ADDR_W+1)'(DEPTH));
    check({tag, ".empty"}, empty, exp_count == '0);
    check({tag, ".ir_read_pointer"}, ir_read_pointer, exp_rp);
    $display("[TB] %s: rd_valid=%0b count=%0d rp=%0d", tag, rd_valid, count, ir_read_pointer);
    wr_exp = 1'b0;
    rd_exp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_req = 1'b0;
    sb_q.delete();
    exp_wp = '0; exp_rp = '0; exp_count = '0; last_rd = '0; wr_exp = 1'b0; rd_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.count", count, 0);
    check("rst.empty", empty, 1);
    check("rst.full", full, 0);
    check("rst.ir_reset_n", ir_reset_n, 0);
    check("rst.rd_valid", rd_valid, 0);
    check("rst.rd_instr", rd_instr, 0);
    check("rst.pointers", {ir_write_pointer, ir_read_pointer}, 0);
    reset = 1'b0;
    wr0_valid = 1'b1;
    rd_req = 1'b1;
    @(posedge clk); #1;
    check("init1.ir_reset_n", ir_reset_n, 0);
    check("init1.wr0_ready", wr0_ready, 0);
    check("init1.ir_load_en", ir_load_en, 0);
    @(posedge clk); #1;
    check("init2.ir_reset_n", ir_reset_n, 1);
    check("init2.count", count, 0);
    check("init2.rd_valid", rd_valid, 0);
    $display("[TB] reset: INIT done, ir_reset_n=%0b", ir_reset_n);
    wr0_valid = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    int i0, i1, g;
    #2;
    do_reset();

    // Contested requests: round-robin alternates starting with requester 0.
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      wr0_valid = 1'b1; wr0_opa = 32'h1000_0000 + i0; wr0_opb = 32'h0000_A000 + i0; wr0_opc = 4'(i0 + 1);
      wr1_valid = 1'b1; wr1_opa = 32'h2000_0000 + i1; wr1_opb = 32'h0000_B000 + i1; wr1_opc = 4'(i1 + 8);
`ifdef INSTR_CTRL_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      expect_grant(g, "arb");
      if (g == 0) i0++; else i1++;
      tick("arb");
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;

    // Drain in order.
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_exp = 1'b1;
      tick("drain");
    end
    rd_req = 1'b0;
    tick("drain_idle");

    // Empty with simultaneous write: read not accepted until the next cycle.
    wr0_valid = 1'b1; wr0_opa = 32'd5; wr0_opb = 32'd3; wr0_opc = 4'd3;
    rd_req = 1'b1;
    expect_grant(0, "add_wr");
    tick("add_wr");
    wr0_valid = 1'b0;
    rd_exp = 1'b1;
    expect_grant(-1, "add_rd");
    tick("add_rd");
    tick("empty_rd");
    rd_req = 1'b0;

    // Fill from a fresh reset so the wrap lands on write_pointer 0.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      wr1_valid = 1'b1; wr1_opa = $urandom; wr1_opb = $urandom; wr1_opc = 4'($urandom);
      expect_grant(1, "fill");
      tick("fill");
    end
    wr1_valid = 1'b0;
    wr0_valid = 1'b1; wr0_opa = 32'hCAFE_0001; wr0_opb = 32'hBEEF_0001; wr0_opc = 4'hE;
    expect_grant(-1, "full_blk");
    tick("full_blk");
    rd_req = 1'b1; rd_exp = 1'b1;
    expect_grant(-1, "full_rd");
    tick("full_rd");
    rd_req = 1'b0;
    expect_grant(0, "wrap_wr");
    tick("wrap_wr");
    wr0_valid = 1'b0;

    rd_req = 1'b1;
    for (int k = 0; k < DEPTH - 3; k++) begin
      rd_exp = 1'b1;
      tick("to3");
    end

    // Simultaneous write and read at count 3.
    wr0_valid = 1'b1; wr0_opa = 32'h1234_5678; wr0_opb = 32'h9ABC_DEF0; wr0_opc = 4'h7;
    rd_exp = 1'b1;
    expect_grant(0, "wr_rd");
    tick("wr_rd");
    rd_req = 1'b0;

    for (int k = 0; k < 5; k++) begin
      wr0_opa = $urandom; wr0_opb = $urandom; wr0_opc = 4'($urandom);
      expect_grant(0, "to8");
      tick("to8");
    end
    wr0_valid = 1'b0;
    rd_req = 1'b1; rd_exp = 1'b1;
    tick("to7");

    // Asynchronous reset mid-stream with a read in flight.
    wr0_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("mid.count", count, 0);
    check("mid.rd_valid", rd_valid, 0);
    check("mid.rd_instr", rd_instr, 0);
    check("mid.pointers", {ir_write_pointer, ir_read_pointer}, 0);
    check("mid.ir_load_en", ir_load_en, 0);
    check("mid.wr0_ready", wr0_ready, 0);
    check("mid.ir_reset_n", ir_reset_n, 0);
    check("mid.empty", empty, 1);
    $display("[TB] mid-stream reset: count=%0d rd_valid=%0b", count, rd_valid);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reinit.ir_reset_n", ir_reset_n, 0);
    check("reinit.wr0_ready", wr0_ready, 0);
    check("reinit.rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check("rerun.ir_reset_n", ir_reset_n, 1);
    wr0_valid = 1'b0; rd_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
